// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per channel a 2-flop synchroniser, counter stability
// filter, press/release/hold strobes and a toggle output.
module debounce_multi #(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned DEBOUNCE_LIMIT    = 250000,
    parameter int unsigned HOLD_LIMIT        = 25000000,
    parameter bit          TOGGLE_ON_RELEASE = 1'b1,
    parameter bit          HOLD_SUPPRESS     = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_switch,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_hold,
    output logic [NUM_CH-1:0] o_toggle
);

    localparam int unsigned DW = $clog2(DEBOUNCE_LIMIT);
    localparam int unsigned HW = $clog2(HOLD_LIMIT + 1);
    localparam logic [DW-1:0] CNT_MAX  = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_LIMIT - 1);

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        logic          sync1_q;
        logic          sync2_q;
        logic          level_q;
        logic          press_q;
        logic          rel_q;
        logic          hold_q;
        logic          hold_seen_q;
        logic          tog_q;
        logic [DW-1:0] cnt_q;
        logic [HW-1:0] hcnt_q;
        logic          tog_evt;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= i_switch[g];
                sync2_q <= sync1_q;
            end
        end

        // Any sample agreeing with the filtered state restarts qualification.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                level_q <= 1'b0;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (sync2_q != level_q) begin
                    if (cnt_q == CNT_MAX) begin
                        level_q <= sync2_q;
                        cnt_q   <= '0;
                        press_q <= sync2_q;
                        rel_q   <= !sync2_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        // Saturating at HOLD_LIMIT makes the strobe fire at most once per press.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                hcnt_q <= '0;
                hold_q <= 1'b0;
            end else begin
                hold_q <= 1'b0;
                if (!level_q) begin
                    hcnt_q <= '0;
                end else if (hcnt_q != HOLD_MAX) begin
                    hcnt_q <= hcnt_q + 1'b1;
                    hold_q <= (hcnt_q == HOLD_PRE);
                end
            end
        end

        // A hold strobe coincident with the release also counts as seen.
        always_comb begin
            tog_evt = 1'b0;
            if (TOGGLE_ON_RELEASE)
                tog_evt = rel_q && !(HOLD_SUPPRESS && (hold_seen_q || hold_q));
            else
                tog_evt = press_q;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                hold_seen_q <= 1'b0;
                tog_q       <= 1'b0;
            end else begin
                if (rel_q)
                    hold_seen_q <= 1'b0;
                else if (hold_q)
                    hold_seen_q <= 1'b1;
                tog_q <= tog_q ^ tog_evt;
            end
        end

        assign o_level[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = rel_q;
        assign o_hold[g]    = hold_q;
        assign o_toggle[g]  = tog_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with DEBOUNCE_LIMIT=4, HOLD_LIMIT=10.
module tb_debounce_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_s;
    logic [3:0] hold;
    logic [3:0] toggle;

    int n_checks;
    int n_pass;

    debounce_multi #(
        .NUM_CH            (4),
        .DEBOUNCE_LIMIT    (4),
        .HOLD_LIMIT        (10),
        .TOGGLE_ON_RELEASE (1'b1),
        .HOLD_SUPPRESS     (1'b1)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_switch  (sw),
        .o_level   (level),
        .o_press   (press),
        .o_release (release_s),
        .o_hold    (hold),
        .o_toggle  (toggle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic       bad;
        n_checks = 0;
        n_pass   = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        sw       = 4'hF;

        // Reset with all inputs high, then release
        tick(3);
        check("rst_level",   level,     4'h0);
        check("rst_press",   press,     4'h0);
        check("rst_release", release_s, 4'h0);
        check("rst_hold",    hold,      4'h0);
        check("rst_toggle",  toggle,    4'h0);
        rst_n = 1'b1;
        tick(5);
        check("init_level_e5", level, 4'h0);
        tick(1);
        check("init_level_e6", level, 4'hF);
        check("init_press_e6", press, 4'hF);
        tick(1);
        check("init_press_e7", press, 4'h0);
        check("init_level_e7", level, 4'hF);
        sw = 4'h0;
        tick(6);
        check("init_release", release_s, 4'hF);
        check("init_rel_lvl", level,     4'h0);
        tick(1);
        check("init_toggle",  toggle,    4'hF);
        check("init_rel_end", release_s, 4'h0);

        // Clean press/release on ch0
        tick(2);
        sw = 4'h1;
        tick(5);
        check("ch0_level_e5", level, 4'h0);
        tick(1);
        check("ch0_level_e6", level, 4'h1);
        check("ch0_press",    press, 4'h1);
        tick(1);
        check("ch0_press_end", press, 4'h0);
        sw = 4'h0;
        tick(6);
        check("ch0_release", release_s, 4'h1);
        tick(1);
        check("ch0_toggle", toggle, 4'hE);

        // Bounce rejection on ch1
        pat = 8'b0111_0111;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sw = {2'b00, pat[i], 1'b0};
            tick(1);
            if (level != 4'h0 || press != 4'h0) bad = 1'b1;
        end
        sw = 4'h2;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (level != 4'h0 || press != 4'h0) bad = 1'b1;
        end
        check("bounce_quiet", {31'b0, bad}, 32'd0);
        tick(1);
        check("bounce_level", level, 4'h2);
        check("bounce_press", press, 4'h2);
        sw = 4'h0;
        tick(6);
        check("ch1_release", release_s, 4'h2);
        tick(1);
        check("ch1_toggle", toggle, 4'hC);

        // Long hold on ch2 with toggle suppression
        sw = 4'h4;
        tick(6);
        check("ch2_press", press, 4'h4);
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            if (hold != 4'h0) bad = 1'b1;
        end
        check("hold_early", {31'b0, bad}, 32'd0);
        tick(1);
        check("hold_fire", hold, 4'h4);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (hold != 4'h0) bad = 1'b1;
        end
        check("hold_once", {31'b0, bad}, 32'd0);
        sw = 4'h0;
        tick(6);
        check("hold_release", release_s, 4'h4);
        tick(1);
        check("hold_suppress", toggle, 4'hC);
        tick(1);
        sw = 4'h4;
        tick(6);
        check("short_press", press, 4'h4);
        sw = 4'h0;
        tick(6);
        check("short_release", release_s, 4'h4);
        check("short_no_hold", hold,      4'h0);
        tick(1);
        check("short_toggle", toggle, 4'h8);

        // Simultaneous ch0 press and ch3 release
        sw = 4'h8;
        tick(6);
        check("ch3_press", press, 4'h8);
        sw = 4'h1;
        tick(6);
        check("sim_press",   press,     4'h1);
        check("sim_release", release_s, 4'h8);
        check("sim_level",   level,     4'h1);
        tick(1);
        check("sim_toggle", toggle, 4'h0);

        // Async reset mid-qualification (ch0 count=2) and mid-hold (ch2 count=5)
        sw = 4'h0;
        tick(8);
        check("pre_toggle", toggle, 4'h1);
        sw = 4'h4;
        tick(6);
        check("ch2_repress", press, 4'h4);
        tick(1);
        sw = 4'h5;
        tick(4);
        check("pre_rst_level", level, 4'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level",  level,  4'h0);
        check("arst_toggle", toggle, 4'h0);
        check("arst_press",  press,  4'h0);
        #5;
        rst_n = 1'b1;
        tick(5);
        check("requal_e5", level, 4'h0);
        tick(1);
        check("requal_level", level, 4'h5);
        check("requal_press", press, 4'h5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
